// File: rtl/control_multiciclo_pkg.sv
// ============================================================================
// control_multiciclo_pkg : opcodes, ALU-mode and mux codes, state encoding
//                          and per-state control decode for the RV32I core.
// Revision 1.0
// ============================================================================
`default_nettype none

package control_multiciclo_pkg;

  localparam logic [6:0] OP_LOAD   = 7'd3;
  localparam logic [6:0] OP_IMM    = 7'd19;
  localparam logic [6:0] OP_AUIPC  = 7'd23;
  localparam logic [6:0] OP_STORE  = 7'd35;
  localparam logic [6:0] OP_REG    = 7'd51;
  localparam logic [6:0] OP_LUI    = 7'd55;
  localparam logic [6:0] OP_BRANCH = 7'd99;
  localparam logic [6:0] OP_JALR   = 7'd103;
  localparam logic [6:0] OP_JAL    = 7'd111;

  localparam logic [1:0] MODO_ADD = 2'b00;
  localparam logic [1:0] MODO_IMM = 2'b01;
  localparam logic [1:0] MODO_REG = 2'b10;
  localparam logic [1:0] MODO_BR  = 2'b11;

  localparam logic [1:0] SEL_A_PC    = 2'b00;
  localparam logic [1:0] SEL_A_PCI   = 2'b01;
  localparam logic [1:0] SEL_A_RS1   = 2'b10;
  localparam logic [1:0] SEL_A_CERO  = 2'b11;

  localparam logic [1:0] SEL_B_RS2    = 2'b00;
  localparam logic [1:0] SEL_B_IMM    = 2'b01;
  localparam logic [1:0] SEL_B_CUATRO = 2'b10;

  localparam logic [1:0] SEL_RES_ALU = 2'b00;
  localparam logic [1:0] SEL_RES_MEM = 2'b01;
  localparam logic [1:0] SEL_RES_PC  = 2'b10;

  // 4-bit encoding shared with the core top level; keep values stable.
  typedef enum logic [3:0] {
    INICIO   = 4'd0,
    FETCH    = 4'd1,
    DECODE   = 4'd2,
    EJEC_R   = 4'd3,
    EJEC_I   = 4'd4,
    LUI      = 4'd5,
    ESC_ALU  = 4'd6,
    DIR_MEM  = 4'd7,
    LEER_MEM = 4'd8,
    ESC_MEM  = 4'd9,
    ESCR_MEM = 4'd10,
    RAMA     = 4'd11,
    JAL      = 4'd12,
    JALR     = 4'd13,
    JALR_ESC = 4'd14
  } estado_t;

  typedef struct packed {
    logic [1:0] modo;
    logic       esc_pc;
    logic       sel_pc;
    logic       esc_ir;
    logic       esc_reg;
    logic       esc_mem;
    logic       sel_dir;
    logic [1:0] sel_a;
    logic [1:0] sel_b;
    logic [1:0] sel_res;
  } ctrl_t;

  // Moore decode; the RAMA esc_pc term depends on cond and is added outside.
  function automatic ctrl_t decodifica(input estado_t e);
    ctrl_t c;
    c = '0;
    case (e)
      FETCH: begin
        c.esc_ir = 1'b1;
        c.sel_a  = SEL_A_PC;
        c.sel_b  = SEL_B_CUATRO;
        c.modo   = MODO_ADD;
        c.esc_pc = 1'b1;
        c.sel_pc = 1'b0;
      end
      DECODE: begin
        c.sel_a = SEL_A_PCI;
        c.sel_b = SEL_B_IMM;
        c.modo  = MODO_ADD;
      end
      EJEC_R: begin
        c.sel_a = SEL_A_RS1;
        c.sel_b = SEL_B_RS2;
        c.modo  = MODO_REG;
      end
      EJEC_I: begin
        c.sel_a = SEL_A_RS1;
        c.sel_b = SEL_B_IMM;
        c.modo  = MODO_IMM;
      end
      LUI: begin
        c.sel_a = SEL_A_CERO;
        c.sel_b = SEL_B_IMM;
        c.modo  = MODO_ADD;
      end
      ESC_ALU: begin
        c.esc_reg = 1'b1;
        c.sel_res = SEL_RES_ALU;
      end
      DIR_MEM, JALR: begin
        c.sel_a = SEL_A_RS1;
        c.sel_b = SEL_B_IMM;
        c.modo  = MODO_ADD;
      end
      LEER_MEM: c.sel_dir = 1'b1;
      ESC_MEM: begin
        c.esc_reg = 1'b1;
        c.sel_res = SEL_RES_MEM;
      end
      ESCR_MEM: begin
        c.sel_dir = 1'b1;
        c.esc_mem = 1'b1;
      end
      RAMA: begin
        c.sel_a  = SEL_A_RS1;
        c.sel_b  = SEL_B_RS2;
        c.modo   = MODO_BR;
        c.sel_pc = 1'b1;
      end
      JAL, JALR_ESC: begin
        c.esc_reg = 1'b1;
        c.sel_res = SEL_RES_PC;
        c.esc_pc  = 1'b1;
        c.sel_pc  = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/control_multiciclo_if.sv
// ============================================================================
// control_multiciclo_if : control bus between the main FSM and the datapath.
// Revision 1.0
// ============================================================================
`default_nettype none

interface control_multiciclo_if;
  logic       hab;
  logic [6:0] op;
  logic       cond;
  logic [1:0] modo;
  logic       esc_pc;
  logic       sel_pc;
  logic       esc_ir;
  logic       esc_reg;
  logic       esc_mem;
  logic       sel_dir;
  logic [1:0] sel_a;
  logic [1:0] sel_b;
  logic [1:0] sel_res;
  logic       op_invalida;

  modport master (
    input  hab, op, cond,
    output modo, esc_pc, sel_pc, esc_ir, esc_reg, esc_mem,
           sel_dir, sel_a, sel_b, sel_res, op_invalida
  );

  modport slave (
    output hab, op, cond,
    input  modo, esc_pc, sel_pc, esc_ir, esc_reg, esc_mem,
           sel_dir, sel_a, sel_b, sel_res, op_invalida
  );
endinterface

`default_nettype wire

// File: rtl/control_multiciclo.sv
// ============================================================================
// control_multiciclo : main multicycle RV32I control FSM, registered
//                      per-state outputs with hab gating of write enables.
// Revision 1.0
// ============================================================================
`default_nettype none

module control_multiciclo (
  input  logic                   clk,
  input  logic                   nreset,
  control_multiciclo_if.master   bus
);
  import control_multiciclo_pkg::*;

  estado_t estado_q, estado_d;
  ctrl_t   ctrl_q, ctrl_d;
  logic    op_valido;

  always_comb begin
    estado_d  = estado_q;
    op_valido = 1'b1;
    case (estado_q)
      INICIO: estado_d = FETCH;
      FETCH:  estado_d = DECODE;
      DECODE: begin
        case (bus.op)
          OP_REG:             estado_d = EJEC_R;
          OP_IMM:             estado_d = EJEC_I;
          OP_LOAD, OP_STORE:  estado_d = DIR_MEM;
          OP_BRANCH:          estado_d = RAMA;
          OP_JAL:             estado_d = JAL;
          OP_JALR:            estado_d = JALR;
          OP_LUI:             estado_d = LUI;
          OP_AUIPC:           estado_d = ESC_ALU;
          default: begin
            estado_d  = FETCH;
            op_valido = 1'b0;
          end
        endcase
      end
      EJEC_R, EJEC_I, LUI: estado_d = ESC_ALU;
      DIR_MEM:  estado_d = (bus.op == OP_LOAD) ? LEER_MEM : ESCR_MEM;
      LEER_MEM: estado_d = ESC_MEM;
      JALR:     estado_d = JALR_ESC;
      ESC_ALU, ESC_MEM, ESCR_MEM, RAMA, JAL, JALR_ESC: estado_d = FETCH;
      default:  estado_d = INICIO;
    endcase
    if (!bus.hab) begin
      estado_d = estado_q;
    end
    // Outputs are registered alongside the state so they always match it.
    ctrl_d = decodifica(estado_d);
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      estado_q <= INICIO;
      ctrl_q   <= '0;
    end else begin
      estado_q <= estado_d;
      ctrl_q   <= ctrl_d;
    end
  end

  assign bus.modo    = ctrl_q.modo;
  assign bus.sel_pc  = ctrl_q.sel_pc;
  assign bus.sel_dir = ctrl_q.sel_dir;
  assign bus.sel_a   = ctrl_q.sel_a;
  assign bus.sel_b   = ctrl_q.sel_b;
  assign bus.sel_res = ctrl_q.sel_res;

  // hab masks write enables combinationally; selects keep the held state.
  assign bus.esc_ir  = bus.hab & ctrl_q.esc_ir;
  assign bus.esc_reg = bus.hab & ctrl_q.esc_reg;
  assign bus.esc_mem = bus.hab & ctrl_q.esc_mem;
  assign bus.esc_pc  = bus.hab & (ctrl_q.esc_pc | ((estado_q == RAMA) & bus.cond));

  assign bus.op_invalida = bus.hab & (estado_q == DECODE) & ~op_valido;

endmodule

`default_nettype wire

// File: tb/tb_control_multiciclo.sv
// ============================================================================
// tb_control_multiciclo : directed per-cycle checks of the control FSM outputs.
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_control_multiciclo;

  logic clk;
  logic nreset;
  int   n_pass;
  int   n_tot;

  control_multiciclo_if u_if ();

  control_multiciclo u_dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (u_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {modo, esc_pc, sel_pc, esc_ir, esc_reg, esc_mem, sel_dir, sel_a, sel_b, sel_res, op_invalida}
  function automatic logic [14:0] mk(input logic [1:0] modo, input logic epc, input logic spc,
                                     input logic eir, input logic ereg, input logic emem,
                                     input logic sdir, input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [1:0] sres, input logic inv);
    return {modo, epc, spc, eir, ereg, emem, sdir, sa, sb, sres, inv};
  endfunction

  localparam logic [14:0] E_ZERO    = 15'd0;
  localparam logic [14:0] E_FETCH   = mk(2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b0);
  localparam logic [14:0] E_FETCH_H = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 1'b0);
  localparam logic [14:0] E_DECODE  = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 1'b0);
  localparam logic [14:0] E_DEC_INV = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1, 2'd0, 1'b1);
  localparam logic [14:0] E_EJEC_R  = mk(2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0);
  localparam logic [14:0] E_EJEC_I  = mk(2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 1'b0);
  localparam logic [14:0] E_LUI     = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd1, 2'd0, 1'b0);
  localparam logic [14:0] E_ESC_ALU = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 1'b0);
  localparam logic [14:0] E_RS1_IMM = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1, 2'd0, 1'b0);
  localparam logic [14:0] E_LEER    = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0);
  localparam logic [14:0] E_ESC_MEM = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd1, 1'b0);
  localparam logic [14:0] E_ESCR    = mk(2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 1'b0);
  localparam logic [14:0] E_RAMA_T  = mk(2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0);
  localparam logic [14:0] E_RAMA_N  = mk(2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0, 2'd0, 1'b0);
  localparam logic [14:0] E_JAL     = mk(2'd0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0, 2'd2, 1'b0);

  function automatic logic [14:0] obs();
    return {u_if.modo, u_if.esc_pc, u_if.sel_pc, u_if.esc_ir, u_if.esc_reg, u_if.esc_mem,
            u_if.sel_dir, u_if.sel_a, u_if.sel_b, u_if.sel_res, u_if.op_invalida};
  endfunction

  task automatic chk(input string tag, input logic [14:0] exp);
    logic [14:0] got;
    got = obs();
    n_tot++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s observed=%b expected=%b", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_pass = 0;
    n_tot  = 0;
    nreset = 1'b0;
    u_if.hab  = 1'b1;
    u_if.op   = 7'd0;
    u_if.cond = 1'b0;

    // Reset and R-type
    #2 chk("rst_async", E_ZERO);
    tick(); chk("rst_hold", E_ZERO);
    @(negedge clk); nreset = 1'b1;
    #1 chk("inicio", E_ZERO);
    tick(); chk("r_fetch", E_FETCH);
    u_if.op = 7'd51;
    tick(); chk("r_decode", E_DECODE);
    tick(); chk("r_ejec", E_EJEC_R);
    tick(); chk("r_esc_alu", E_ESC_ALU);
    tick(); chk("r_fetch5", E_FETCH);

    // Load
    u_if.op = 7'd3;
    tick(); chk("ld_decode", E_DECODE);
    tick(); chk("ld_dir", E_RS1_IMM);
    tick(); chk("ld_leer", E_LEER);
    tick(); chk("ld_esc_mem", E_ESC_MEM);
    tick(); chk("ld_fetch", E_FETCH);

    // Store
    u_if.op = 7'd35;
    tick(); chk("st_decode", E_DECODE);
    tick(); chk("st_dir", E_RS1_IMM);
    tick(); chk("st_escr", E_ESCR);
    tick(); chk("st_fetch", E_FETCH);

    // Branch taken, with cond toggled inside RAMA
    u_if.op = 7'd99;
    tick(); chk("br_t_decode", E_DECODE);
    u_if.cond = 1'b1;
    tick(); chk("br_t_rama", E_RAMA_T);
    u_if.cond = 1'b0;
    #1 chk("br_cond_comb", E_RAMA_N);
    u_if.cond = 1'b1;
    tick(); chk("br_t_fetch", E_FETCH);

    // Branch not taken
    u_if.cond = 1'b0;
    tick(); chk("br_n_decode", E_DECODE);
    tick(); chk("br_n_rama", E_RAMA_N);
    tick(); chk("br_n_fetch", E_FETCH);

    // Invalid opcode
    u_if.op = 7'h7F;
    tick(); chk("inv_decode", E_DEC_INV);
    tick(); chk("inv_fetch", E_FETCH);

    // JAL
    u_if.op = 7'd111;
    tick(); chk("jal_decode", E_DECODE);
    tick(); chk("jal", E_JAL);
    tick(); chk("jal_fetch", E_FETCH);

    // JALR
    u_if.op = 7'd103;
    tick(); chk("jalr_decode", E_DECODE);
    tick(); chk("jalr", E_RS1_IMM);
    tick(); chk("jalr_esc", E_JAL);
    tick(); chk("jalr_fetch", E_FETCH);

    // LUI
    u_if.op = 7'd55;
    tick(); chk("lui_decode", E_DECODE);
    tick(); chk("lui", E_LUI);
    tick(); chk("lui_esc", E_ESC_ALU);
    tick(); chk("lui_fetch", E_FETCH);

    // AUIPC
    u_if.op = 7'd23;
    tick(); chk("auipc_decode", E_DECODE);
    tick(); chk("auipc_esc", E_ESC_ALU);
    tick(); chk("auipc_fetch", E_FETCH);

    // I-type, with a hab freeze in FETCH first
    u_if.op  = 7'd19;
    u_if.hab = 1'b0;
    #1 chk("hab_fetch_mask", E_FETCH_H);
    tick(); chk("hab_fetch_hold", E_FETCH_H);
    u_if.hab = 1'b1;
    #1 chk("hab_fetch_resume", E_FETCH);
    tick(); chk("i_decode", E_DECODE);
    tick(); chk("i_ejec", E_EJEC_I);
    tick(); chk("i_esc", E_ESC_ALU);
    tick(); chk("i_fetch", E_FETCH);

    // hab=0 held for three cycles in ESC_ALU
    u_if.op = 7'd51;
    tick(); chk("h_decode", E_DECODE);
    tick(); chk("h_ejec", E_EJEC_R);
    tick(); chk("h_esc_alu", E_ESC_ALU);
    u_if.hab = 1'b0;
    #1 chk("h_mask", E_ZERO);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("h_hold", E_ZERO);
    end
    u_if.hab = 1'b1;
    #1 chk("h_resume", E_ESC_ALU);
    tick(); chk("h_fetch", E_FETCH);

    // Reset aborts a load in LEER_MEM
    u_if.op = 7'd3;
    tick(); chk("ra_decode", E_DECODE);
    tick(); chk("ra_dir", E_RS1_IMM);
    tick(); chk("ra_leer", E_LEER);
    #2 nreset = 1'b0;
    #1 chk("ra_async", E_ZERO);
    tick(); chk("ra_hold", E_ZERO);
    @(negedge clk); nreset = 1'b1;
    #1 chk("ra_inicio", E_ZERO);
    tick(); chk("ra_fetch", E_FETCH);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

`default_nettype wire
